// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, control-bit
// positions and the interlock state encoding.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_e;

  localparam int CTRL_REG_WE  = 7;
  localparam int CTRL_MEM_RD  = 6;
  localparam int CTRL_MEM_WR  = 5;
  localparam int CTRL_BRANCH  = 4;
  localparam int CTRL_JAL     = 3;
  localparam int CTRL_JALR    = 2;
  localparam int CTRL_SRC_IMM = 1;
  localparam int CTRL_ILLEGAL = 0;

  typedef enum logic {
    ST_RUN,
    ST_BUBBLE
  } state_e;

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate extraction for the RV32I formats, sign-extended to XLEN.
// Opcodes without an immediate produce zero.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{(XLEN-12){instr[31]}}, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      OPC_JAL:
        imm = {{(XLEN-20){instr[31]}}, instr[19:12],
               instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: register-file read with write-back bypass, decode,
// and the ID/EX register with stall, flush and load-use interlock.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic [RADDR-1:0] rf_adrs_r1,
  output logic [RADDR-1:0] rf_adrs_r2,
  input  logic [XLEN-1:0]  rf_data_r1,
  input  logic [XLEN-1:0]  rf_data_r2,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_adrs,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RADDR-1:0] ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic [7:0]       ex_ctrl
);

  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [RADDR-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]  imm, rs1_val, rs2_val;
  alu_op_e          alu_op;
  logic             has_rd, uses_rs2, illegal, src_imm;
  logic             mem_rd, mem_wr, branch, jal, jalr;
  logic [7:0]       ctrl;
  logic             advance, hazard, accept;

  state_e           state_q, state_d;
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]  ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0]  ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [RADDR-1:0] ex_rd_q, ex_rd_d;
  logic [3:0]       ex_alu_op_q, ex_alu_op_d;
  logic [7:0]       ex_ctrl_q, ex_ctrl_d;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign funct7 = if_instr[31:25];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  assign rf_adrs_r1 = rs1;
  assign rf_adrs_r2 = rs2;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  // The register file commits wb_data at the same edge, so forward it.
  always_comb begin
    rs1_val = rf_data_r1;
    if (rs1 == '0)
      rs1_val = '0;
    else if (wb_we && wb_adrs == rs1)
      rs1_val = wb_data;
    rs2_val = rf_data_r2;
    if (rs2 == '0)
      rs2_val = '0;
    else if (wb_we && wb_adrs == rs2)
      rs2_val = wb_data;
  end

  always_comb begin
    has_rd   = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    src_imm  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    branch   = 1'b0;
    jal      = 1'b0;
    jalr     = 1'b0;
    alu_op   = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        has_rd  = 1'b1;
        src_imm = 1'b1;
        alu_op  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        has_rd  = 1'b1;
        src_imm = 1'b1;
      end
      OPC_JAL: begin
        has_rd = 1'b1;
        jal    = 1'b1;
      end
      OPC_JALR: begin
        has_rd  = 1'b1;
        jalr    = 1'b1;
        src_imm = 1'b1;
        illegal = funct3 != 3'b000;
      end
      OPC_BRANCH: begin
        uses_rs2 = 1'b1;
        branch   = 1'b1;
        case (funct3)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        has_rd  = 1'b1;
        mem_rd  = 1'b1;
        src_imm = 1'b1;
        illegal = !(funct3 inside {3'b000, 3'b001, 3'b010,
                                   3'b100, 3'b101});
      end
      OPC_STORE: begin
        uses_rs2 = 1'b1;
        mem_wr   = 1'b1;
        src_imm  = 1'b1;
        illegal  = funct3 > 3'b010;
      end
      OPC_OPIMM: begin
        has_rd  = 1'b1;
        src_imm = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            alu_op  = ALU_SLL;
            illegal = funct7 != 7'h00;
          end
          default: begin
            if (funct7 == 7'h00)
              alu_op = ALU_SRL;
            else if (funct7 == 7'h20)
              alu_op = ALU_SRA;
            else
              illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        has_rd   = 1'b1;
        uses_rs2 = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_011: alu_op = ALU_SLTU;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0100000_101: alu_op = ALU_SRA;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_111: alu_op = ALU_AND;
          default:         illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Illegal instructions travel to EX with every side effect suppressed.
    if (illegal) begin
      has_rd  = 1'b0;
      src_imm = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      branch  = 1'b0;
      jal     = 1'b0;
      jalr    = 1'b0;
      alu_op  = ALU_ADD;
    end
  end

  always_comb begin
    ctrl               = '0;
    ctrl[CTRL_REG_WE]  = has_rd && rd != '0;
    ctrl[CTRL_MEM_RD]  = mem_rd;
    ctrl[CTRL_MEM_WR]  = mem_wr;
    ctrl[CTRL_BRANCH]  = branch;
    ctrl[CTRL_JAL]     = jal;
    ctrl[CTRL_JALR]    = jalr;
    ctrl[CTRL_SRC_IMM] = src_imm;
    ctrl[CTRL_ILLEGAL] = illegal;
  end

  assign advance = !ex_valid_q || ex_ready;
  assign hazard  = ex_valid_q && ex_ready && ex_ctrl_q[CTRL_MEM_RD] &&
                   ex_rd_q != '0 &&
                   (ex_rd_q == rs1 || (uses_rs2 && ex_rd_q == rs2));
  assign if_ready = !rst && advance && state_q == ST_RUN && !hazard;
  assign accept   = if_valid && if_ready && !flush;

  always_comb begin
    state_d     = ST_RUN;
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_imm_d    = ex_imm_q;
    ex_rd_d     = ex_rd_q;
    ex_alu_op_d = ex_alu_op_q;
    ex_ctrl_d   = ex_ctrl_q;
    if (!flush && state_q == ST_RUN && hazard && if_valid)
      state_d = ST_BUBBLE;
    if (accept) begin
      ex_valid_d  = 1'b1;
      ex_pc_d     = if_pc;
      ex_rs1_d    = rs1_val;
      ex_rs2_d    = rs2_val;
      ex_imm_d    = imm;
      ex_rd_d     = has_rd ? rd : '0;
      ex_alu_op_d = alu_op;
      ex_ctrl_d   = ctrl;
    end else if (advance || flush) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_imm_q    <= '0;
      ex_rd_q     <= '0;
      ex_alu_op_q <= '0;
      ex_ctrl_q   <= '0;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_imm_q    <= ex_imm_d;
      ex_rd_q     <= ex_rd_d;
      ex_alu_op_q <= ex_alu_op_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1_val = ex_rs1_q;
  assign ex_rs2_val = ex_rs2_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd      = ex_rd_q;
  assign ex_alu_op  = ex_alu_op_q;
  assign ex_ctrl    = ex_ctrl_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the stage.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_adrs_r1, rf_adrs_r2;
  logic [31:0] rf_data_r1, rf_data_r2;
  logic        wb_we;
  logic [4:0]  wb_adrs;
  logic [31:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [7:0]  ex_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .rf_adrs_r1 (rf_adrs_r1),
    .rf_adrs_r2 (rf_adrs_r2),
    .rf_data_r1 (rf_data_r1),
    .rf_data_r2 (rf_data_r2),
    .wb_we      (wb_we),
    .wb_adrs    (wb_adrs),
    .wb_data    (wb_data),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_imm     (ex_imm),
    .ex_rd      (ex_rd),
    .ex_alu_op  (ex_alu_op),
    .ex_ctrl    (ex_ctrl)
  );

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [7:0]  ctrl;
    bit          rs2u;
  } dec_t;

  // Expected ID/EX contents and interlock state.
  bit          m_valid, m_bub;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  logic [3:0]  m_op;
  logic [7:0]  m_ctrl;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ctrl = {reg_we, mem_rd, mem_wr, branch, jal, jalr, src_imm, illegal}
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t        d;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [11:0] t12;
    logic [12:0] t13;
    logic [20:0] t21;
    bit          ok, wr;
    int          tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    f7 = i[31:25];
    f3 = i[14:12];
    d.imm = 0; d.rd = 0; d.op = 0; d.ctrl = 0;
    ok = 1; wr = 0;
    d.rs2u = i[6:0] inside {7'h33, 7'h23, 7'h63};
    t12 = i[31:20];
    case (i[6:0])
      7'h37: begin
        d.imm = {i[31:12], 12'h0}; wr = 1; d.op = 10; d.ctrl[1] = 1;
      end
      7'h17: begin
        d.imm = {i[31:12], 12'h0}; wr = 1; d.ctrl[1] = 1;
      end
      7'h6F: begin
        t21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.imm = int'($signed(t21)); wr = 1; d.ctrl[3] = 1;
      end
      7'h67: begin
        d.imm = int'($signed(t12)); wr = 1;
        d.ctrl[2] = 1; d.ctrl[1] = 1; ok = (f3 == 0);
      end
      7'h63: begin
        t13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        d.imm = int'($signed(t13)); d.ctrl[4] = 1;
        if (f3 < 2) d.op = 1;
        else if (f3 == 4 || f3 == 5) d.op = 3;
        else if (f3 >= 6) d.op = 4;
        else ok = 0;
      end
      7'h03: begin
        d.imm = int'($signed(t12)); wr = 1;
        d.ctrl[6] = 1; d.ctrl[1] = 1; ok = (f3 != 3 && f3 < 6);
      end
      7'h23: begin
        t12 = {i[31:25], i[11:7]};
        d.imm = int'($signed(t12));
        d.ctrl[5] = 1; d.ctrl[1] = 1; ok = (f3 < 3);
      end
      7'h13: begin
        d.imm = int'($signed(t12)); wr = 1; d.ctrl[1] = 1;
        d.op = 4'(tbl[f3]);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          if (f7 == 7'h20) d.op = 7;
          else ok = (f7 == 0);
        end
      end
      7'h33: begin
        wr = 1; d.op = 4'(tbl[f3]);
        if (f7 == 7'h20) begin
          if (f3 == 0) d.op = 1;
          else if (f3 == 5) d.op = 7;
          else ok = 0;
        end else ok = (f7 == 0);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      d.rd = 0; d.op = 0; d.ctrl = 8'h01;
    end else begin
      d.rd = wr ? i[11:7] : 5'd0;
      d.ctrl[7] = wr && (i[11:7] != 0);
    end
    return d;
  endfunction

  function automatic logic [31:0] opv(input logic [4:0] rs,
                                      input logic [31:0] rf);
    if (rs == 0) return 0;
    if (wb_we && wb_adrs == rs) return wb_data;
    return rf;
  endfunction

  // One clock: check combinational outputs, advance the model, check ID/EX.
  task automatic step();
    logic [4:0] s1, s2;
    bit         haz, rdy, acc, adv;
    dec_t       d;
    #1;
    s1 = if_instr[19:15];
    s2 = if_instr[24:20];
    d = ref_decode(if_instr);
    haz = m_valid && ex_ready && m_ctrl[6] && m_rd != 0 &&
          (m_rd == s1 || (d.rs2u && m_rd == s2));
    adv = !m_valid || ex_ready;
    rdy = !rst && adv && !m_bub && !haz;
    chk("if_ready", if_ready, rdy);
    chk("rf_adrs_r1", rf_adrs_r1, s1);
    chk("rf_adrs_r2", rf_adrs_r2, s2);
    if (rst) begin
      m_valid = 0; m_bub = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
      m_imm = 0; m_rd = 0; m_op = 0; m_ctrl = 0;
    end else begin
      acc = if_valid && rdy && !flush;
      if (acc) begin
        m_valid = 1; m_pc = if_pc;
        m_rs1 = opv(s1, rf_data_r1);
        m_rs2 = opv(s2, rf_data_r2);
        m_imm = d.imm; m_rd = d.rd; m_op = d.op; m_ctrl = d.ctrl;
      end else if (adv || flush) begin
        m_valid = 0;
      end
      m_bub = !flush && !m_bub && haz && if_valid;
    end
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rs1_val", ex_rs1_val, m_rs1);
    chk("ex_rs2_val", ex_rs2_val, m_rs2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rd", ex_rd, m_rd);
    chk("ex_alu_op", ex_alu_op, m_op);
    chk("ex_ctrl", ex_ctrl, m_ctrl);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[10];
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
            7'h03, 7'h23, 7'h13, 7'h33, 7'h03};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = ops[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 2) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
    return w;
  endfunction

  initial begin
    m_valid = 0; m_bub = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0;
    m_imm = 0; m_rd = 0; m_op = 0; m_ctrl = 0;
    rst = 1; if_valid = 0; if_instr = 0; if_pc = 0;
    rf_data_r1 = 0; rf_data_r2 = 0; wb_we = 0; wb_adrs = 0;
    wb_data = 0; flush = 0; ex_ready = 0;
    step();
    step();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    rst = 0; ex_ready = 1;
    #1;
    chk("release_if_ready", if_ready, 1);

    // addi x5,x0,-1
    if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h100;
    rf_data_r1 = 32'h55; rf_data_r2 = 32'h66;
    step();
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", ex_rd, 5);
    chk("addi_we", ex_ctrl[7], 1);
    chk("addi_rs1", ex_rs1_val, 0);

    // add x3,x1,x2 with bypass, then with wb to x0
    if_instr = 32'h002081B3; if_pc = 32'h104;
    rf_data_r1 = 7; wb_we = 1; wb_adrs = 1; wb_data = 9;
    step();
    chk("bypass_rs1", ex_rs1_val, 9);
    wb_adrs = 0; if_pc = 32'h108;
    step();
    chk("x0_no_bypass", ex_rs1_val, 7);
    wb_we = 0;

    // lw x4,0(x1) then add x6,x4,x4
    if_instr = 32'h0000A203; if_pc = 32'h10C;
    step();
    chk("lw_mem_rd", ex_ctrl[6], 1);
    if_instr = 32'h00420333; if_pc = 32'h110;
    step();
    chk("load_use_bubble", ex_valid, 0);
    step();
    step();
    chk("load_use_add_valid", ex_valid, 1);
    chk("load_use_add_rd", ex_rd, 6);

    // stall for 3 cycles, then resume
    if_instr = 32'h00500393; if_pc = 32'h114; ex_ready = 0;
    repeat (3) step();
    chk("stall_rd", ex_rd, 6);
    ex_ready = 1;
    step();
    chk("resume_rd", ex_rd, 7);

    // flush kills the incoming instruction
    flush = 1; if_pc = 32'h118;
    step();
    chk("flush_valid", ex_valid, 0);
    flush = 0; if_instr = 32'h0000007F; if_pc = 32'h11C;
    step();
    chk("illegal_bit", ex_ctrl[0], 1);
    chk("illegal_we", ex_ctrl[7], 0);

    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      if_valid   = ($urandom_range(0, 9) < 8);
      ex_ready   = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      if_instr   = rand_instr();
      if_pc      = $urandom;
      rf_data_r1 = $urandom;
      rf_data_r2 = $urandom;
      wb_we      = ($urandom_range(0, 1) != 0);
      wb_adrs    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
